// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - two-port 32-bit to 16-bit DRAM FIFO arbiter; DRAM_ARB_RR_EN selects round-robin ties
module dram_port_arbiter #(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [31:0]       req0_wdata,
    output logic              req0_ack,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [31:0]       req1_wdata,
    output logic              req1_ack,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic [15:0]       fifo_wr_data,
    output logic [ADDR_W:0]   fifo_wr_addr,
    output logic              fifo_wr,
    input  logic              fifo_wr_full,
    output logic [ADDR_W:0]   fifo_rd_addr,
    output logic              fifo_rd_req,
    input  logic              fifo_rd_busy,
    input  logic [15:0]       fifo_rd_data,
    input  logic              fifo_rd_empty,
    output logic              fifo_rd_ack
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR_LO = 3'd1;
    localparam logic [2:0] S_WR_HI = 3'd2;
    localparam logic [2:0] S_RC_LO = 3'd3;
    localparam logic [2:0] S_RC_HI = 3'd4;
    localparam logic [2:0] S_RD_LO = 3'd5;
    localparam logic [2:0] S_RD_HI = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic              grant;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic              pick;
    logic              any_req;
    logic              win_we;

    assign any_req = req0_valid || req1_valid;
    assign win_we  = pick ? req1_we : req0_we;

`ifdef DRAM_ARB_RR_EN
    // prefer1 holds the tie winner: the port that was not served last
    logic prefer1;
    always_comb begin
        pick = !req0_valid;
        if (req0_valid && req1_valid)
            pick = prefer1;
    end
`else
    always_comb pick = !req0_valid;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (any_req) state_nx = win_we ? S_WR_LO : S_RC_LO;
            S_WR_LO: if (!fifo_wr_full) state_nx = S_WR_HI;
            S_WR_HI: if (!fifo_wr_full) state_nx = S_DONE;
            S_RC_LO: if (!fifo_rd_busy) state_nx = S_RC_HI;
            S_RC_HI: if (!fifo_rd_busy) state_nx = S_RD_LO;
            S_RD_LO: if (!fifo_rd_empty) state_nx = S_RD_HI;
            S_RD_HI: if (!fifo_rd_empty) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            grant     <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata     <= '0;
`ifdef DRAM_ARB_RR_EN
            prefer1   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            // requester inputs are only sampled here; a waiting port is ignored
            if (state == S_IDLE && any_req) begin
                grant     <= pick;
                lat_addr  <= pick ? req1_addr : req0_addr;
                lat_wdata <= pick ? req1_wdata : req0_wdata;
            end
            if (state == S_RD_LO && !fifo_rd_empty)
                rdata[15:0] <= fifo_rd_data;
            if (state == S_RD_HI && !fifo_rd_empty)
                rdata[31:16] <= fifo_rd_data;
`ifdef DRAM_ARB_RR_EN
            if (state == S_DONE)
                prefer1 <= !grant;
`endif
        end
    end

    always_comb begin
        fifo_wr      = 1'b0;
        fifo_wr_addr = '0;
        fifo_wr_data = '0;
        fifo_rd_req  = 1'b0;
        fifo_rd_addr = '0;
        fifo_rd_ack  = 1'b0;
        case (state)
            S_WR_LO: begin
                fifo_wr      = !fifo_wr_full;
                fifo_wr_addr = {lat_addr, 1'b0};
                fifo_wr_data = lat_wdata[15:0];
            end
            S_WR_HI: begin
                fifo_wr      = !fifo_wr_full;
                fifo_wr_addr = {lat_addr, 1'b1};
                fifo_wr_data = lat_wdata[31:16];
            end
            S_RC_LO: begin
                fifo_rd_req  = !fifo_rd_busy;
                fifo_rd_addr = {lat_addr, 1'b0};
            end
            S_RC_HI: begin
                fifo_rd_req  = !fifo_rd_busy;
                fifo_rd_addr = {lat_addr, 1'b1};
            end
            S_RD_LO, S_RD_HI: fifo_rd_ack = !fifo_rd_empty;
            default: ;
        endcase
    end

    assign busy     = (state != S_IDLE);
    assign req0_ack = (state == S_DONE) && !grant;
    assign req1_ack = (state == S_DONE) && grant;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - randomized self-checking bench for dram_port_arbiter with a DRAM FIFO model
module tb_dram_port_arbiter;

`ifdef DRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk, rst;
    logic        req0_valid, req0_we, req0_ack;
    logic [23:0] req0_addr;
    logic [31:0] req0_wdata;
    logic        req1_valid, req1_we, req1_ack;
    logic [23:0] req1_addr;
    logic [31:0] req1_wdata;
    logic [31:0] rdata;
    logic        busy;
    logic [15:0] fifo_wr_data;
    logic [24:0] fifo_wr_addr;
    logic        fifo_wr, fifo_wr_full;
    logic [24:0] fifo_rd_addr;
    logic        fifo_rd_req, fifo_rd_busy;
    logic [15:0] fifo_rd_data;
    logic        fifo_rd_empty, fifo_rd_ack;

    int vectors = 0;
    int miscompares = 0;

    dram_port_arbiter #(.ADDR_W(24)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ack(req0_ack),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ack(req1_ack),
        .rdata(rdata), .busy(busy),
        .fifo_wr_data(fifo_wr_data), .fifo_wr_addr(fifo_wr_addr), .fifo_wr(fifo_wr),
        .fifo_wr_full(fifo_wr_full),
        .fifo_rd_addr(fifo_rd_addr), .fifo_rd_req(fifo_rd_req), .fifo_rd_busy(fifo_rd_busy),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty), .fifo_rd_ack(fifo_rd_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DRAM contents by halfword address, word-level expectation, FIFO traffic logs
    logic [15:0] dram [logic [24:0]];
    logic [31:0] wmem [logic [23:0]];
    logic [15:0] resp_q[$];
    logic [40:0] wr_log[$];
    logic [24:0] rd_log[$];
    int  p_full = 0, p_busy = 0, p_empty = 0;
    int  full_hold = 0, empty_hold = 0;
    bit  hold_full_on_lo = 0, hold_empty_on_lo = 0;
    bit  last_grant = 0;

    function automatic logic [15:0] pat(input logic [24:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    function automatic logic [15:0] dram_rd(input logic [24:0] a);
        return dram.exists(a) ? dram[a] : pat(a);
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        return wmem.exists(a) ? wmem[a] : {pat({a, 1'b1}), pat({a, 1'b0})};
    endfunction

    // FIFO side: drive flags at negedge, observe the resulting pushes/pops just before posedge
    always begin
        bit stall_e;
        @(negedge clk);
        fifo_wr_full = (full_hold > 0) || ($urandom_range(99) < p_full);
        if (full_hold > 0) full_hold--;
        fifo_rd_busy = ($urandom_range(99) < p_busy);
        stall_e = (empty_hold > 0) || ($urandom_range(99) < p_empty);
        if (empty_hold > 0) empty_hold--;
        fifo_rd_empty = (resp_q.size() == 0) || stall_e;
        fifo_rd_data = (resp_q.size() != 0) ? resp_q[0] : 16'h0000;
        #1;
        vectors++;
        if ((fifo_wr && fifo_wr_full) || (fifo_rd_ack && fifo_rd_empty)
            || (int'(fifo_wr) + int'(fifo_rd_req) + int'(fifo_rd_ack) > 1)) begin
            miscompares++;
            $display("FAIL fifo_protocol: wr=%b full=%b rd_req=%b rd_ack=%b empty=%b at %0t required no push on full, no pop on empty, one op per cycle",
                     fifo_wr, fifo_wr_full, fifo_rd_req, fifo_rd_ack, fifo_rd_empty, $time);
        end
        if (fifo_wr) begin
            dram[fifo_wr_addr] = fifo_wr_data;
            wr_log.push_back({fifo_wr_addr, fifo_wr_data});
            if (hold_full_on_lo && !fifo_wr_addr[0]) begin
                full_hold = 4;
                hold_full_on_lo = 0;
            end
        end
        if (fifo_rd_req) begin
            rd_log.push_back(fifo_rd_addr);
            resp_q.push_back(dram_rd(fifo_rd_addr));
        end
        if (fifo_rd_ack) begin
            void'(resp_q.pop_front());
            if (hold_empty_on_lo) begin
                empty_hold = 6;
                hold_empty_on_lo = 0;
            end
        end
    end

    task automatic do_req(input int port, input bit we, input logic [23:0] addr,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd);
        bit ok = 0;
        lat = 0;
        rd  = 'x;
        @(negedge clk);
        if (port == 0) begin
            req0_we = we; req0_addr = addr; req0_wdata = wd; req0_valid = 1;
        end else begin
            req1_we = we; req1_addr = addr; req1_wdata = wd; req1_valid = 1;
        end
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if ((port == 0 && req0_ack) || (port == 1 && req1_ack)) begin
                lat = n; rd = rdata; ok = 1;
                break;
            end
        end
        req0_valid = 0;
        req1_valid = 0;
        if (ok) last_grant = (port == 1);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL req_timeout: port %0d got no ack within 300 cycles, required an ack", port);
        end
    endtask

    task automatic check_wr_log(input string name, input logic [23:0] a, input logic [31:0] wd);
        vectors++;
        if (wr_log.size() != 2 || wr_log[0] !== {a, 1'b0, wd[15:0]} || wr_log[1] !== {a, 1'b1, wd[31:16]}) begin
            miscompares++;
            $display("FAIL %s_wr_pushes: got %0d pushes first=%h required {%h,%h},{%h,%h}",
                     name, wr_log.size(), (wr_log.size() != 0) ? wr_log[0] : 41'h0,
                     {a, 1'b0}, wd[15:0], {a, 1'b1}, wd[31:16]);
        end
    endtask

    task automatic check_rd_log(input string name, input logic [23:0] a);
        vectors++;
        if (rd_log.size() != 2 || rd_log[0] !== {a, 1'b0} || rd_log[1] !== {a, 1'b1}) begin
            miscompares++;
            $display("FAIL %s_rd_cmds: got %0d commands first=%h required %h,%h",
                     name, rd_log.size(), (rd_log.size() != 0) ? rd_log[0] : 25'h0, {a, 1'b0}, {a, 1'b1});
        end
    endtask

    task automatic check_outputs_zero(input string name);
        logic [103:0] outs;
        outs = {req0_ack, req1_ack, rdata, busy, fifo_wr_data, fifo_wr_addr, fifo_wr,
                fifo_rd_addr, fifo_rd_req, fifo_rd_ack};
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL %s: outputs %h required all zero", name, outs);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_outputs");
        rst = 0;
    endtask

    task automatic test_write_basic;
        wr_log.delete();
        @(negedge clk);
        req0_we = 1; req0_addr = 24'h000010; req0_wdata = 32'hDEADBEEF; req0_valid = 1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            vectors++;
            if (busy !== (n <= 3) || req0_ack !== (n == 3) || req1_ack !== 1'b0) begin
                miscompares++;
                $display("FAIL write_timing: cycle T+%0d busy=%b ack0=%b ack1=%b required busy=%b ack0=%b ack1=0",
                         n, busy, req0_ack, req1_ack, n <= 3, n == 3);
            end
            if (n == 3) req0_valid = 0;
        end
        wmem[24'h000010] = 32'hDEADBEEF;
        check_wr_log("write_basic", 24'h000010, 32'hDEADBEEF);
    endtask

    task automatic test_read_basic;
        int lat;
        logic [31:0] rd;
        rd_log.delete();
        dram[25'h06] = 16'h5678;
        dram[25'h07] = 16'h1234;
        wmem[24'h000003] = 32'h12345678;
        do_req(1, 0, 24'h000003, 32'h0, lat, rd);
        vectors++;
        if (lat != 5 || rd !== 32'h12345678) begin
            miscompares++;
            $display("FAIL read_basic: latency %0d rdata %h required 5 and 12345678", lat, rd);
        end
        check_rd_log("read_basic", 24'h000003);
    endtask

    task automatic test_wr_full;
        int lat;
        logic [31:0] rd;
        wr_log.delete();
        hold_full_on_lo = 1;
        do_req(0, 1, 24'h000100, 32'hCAFEF00D, lat, rd);
        wmem[24'h000100] = 32'hCAFEF00D;
        vectors++;
        if (lat != 7) begin
            miscompares++;
            $display("FAIL wr_full_latency: got %0d required 7", lat);
        end
        check_wr_log("wr_full", 24'h000100, 32'hCAFEF00D);
    endtask

    task automatic test_rd_empty;
        int lat, extra;
        logic [31:0] rd;
        rd_log.delete();
        hold_empty_on_lo = 1;
        do_req(0, 0, 24'h000200, 32'h0, lat, rd);
        vectors++;
        if (lat != 11 || rd !== exp_word(24'h000200)) begin
            miscompares++;
            $display("FAIL rd_empty: latency %0d rdata %h required 11 and %h", lat, rd, exp_word(24'h000200));
        end
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (req0_ack || req1_ack) extra++;
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL rd_empty_single_ack: got %0d extra acks required 0", extra);
        end
    endtask

    task automatic test_wrap;
        int lat;
        logic [31:0] rd;
        wr_log.delete();
        rd_log.delete();
        do_req(0, 1, 24'hFFFFFF, 32'h0BADF00D, lat, rd);
        wmem[24'hFFFFFF] = 32'h0BADF00D;
        check_wr_log("wrap", 24'hFFFFFF, 32'h0BADF00D);
        do_req(1, 0, 24'hFFFFFF, 32'h0, lat, rd);
        vectors++;
        if (rd !== 32'h0BADF00D) begin
            miscompares++;
            $display("FAIL wrap_readback: got %h required 0badf00d", rd);
        end
        check_rd_log("wrap", 24'hFFFFFF);
    endtask

    task automatic test_reset_mid;
        int lat, acks;
        logic [31:0] rd;
        empty_hold = 50;
        @(negedge clk);
        req0_we = 0; req0_addr = 24'h000005; req0_valid = 1;
        repeat (5) @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || fifo_rd_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_setup: busy=%b rd_ack=%b required 1 and 0", busy, fifo_rd_ack);
        end
        #2 rst = 1;
        #1 check_outputs_zero("reset_mid_outputs");
        req0_valid = 0;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (req0_ack || req1_ack || fifo_wr || fifo_rd_req) acks++;
        end
        rst = 0;
        resp_q.delete();
        empty_hold = 0;
        last_grant = 1;
        vectors++;
        if (acks != 0) begin
            miscompares++;
            $display("FAIL reset_mid_quiet: got %0d ack/push cycles in reset required 0", acks);
        end
        wr_log.delete();
        do_req(0, 1, 24'h000777, 32'h13579BDF, lat, rd);
        wmem[24'h000777] = 32'h13579BDF;
        vectors++;
        if (lat != 3) begin
            miscompares++;
            $display("FAIL reset_mid_recover_latency: got %0d required 3", lat);
        end
        check_wr_log("reset_mid_recover", 24'h000777, 32'h13579BDF);
    endtask

    task automatic test_arbitration;
        bit exp_w, winner, got;
        logic [31:0] d0, d1;
        @(negedge clk) rst = 1;
        @(negedge clk) rst = 0;
        last_grant = 1;
        for (int r = 0; r < 4; r++) begin
            d0 = $urandom;
            d1 = $urandom;
            @(negedge clk);
            req0_we = 1; req0_addr = 24'h000400 + 24'(r); req0_wdata = d0; req0_valid = 1;
            req1_we = 1; req1_addr = 24'h000500 + 24'(r); req1_wdata = d1; req1_valid = 1;
            exp_w = RR ? !last_grant : 1'b0;
            got = 0;
            winner = 0;
            for (int n = 0; n < 50 && !got; n++) begin
                @(negedge clk);
                if (req0_ack || req1_ack) begin got = 1; winner = req1_ack; end
            end
            vectors++;
            if (!got || winner !== exp_w || (req0_ack && req1_ack)) begin
                miscompares++;
                $display("FAIL arb_round%0d: got grant %0d (acked=%b) required %0d", r, winner, got, exp_w);
            end
            if (winner) wmem[24'h000500 + 24'(r)] = d1; else wmem[24'h000400 + 24'(r)] = d0;
            last_grant = winner;
            if (r < 3) begin
                req0_valid = 0; req1_valid = 0;
            end else begin
                // the loser keeps valid held and must be served next
                if (winner) req1_valid = 0; else req0_valid = 0;
                got = 0;
                for (int n = 0; n < 50 && !got; n++) begin
                    @(negedge clk);
                    if ((winner && req0_ack) || (!winner && req1_ack)) got = 1;
                end
                req0_valid = 0; req1_valid = 0;
                vectors++;
                if (!got) begin
                    miscompares++;
                    $display("FAIL arb_loser_served: port %0d not acked required an ack", !winner);
                end
                if (winner) wmem[24'h000400 + 24'(r)] = d0; else wmem[24'h000500 + 24'(r)] = d1;
                last_grant = !winner;
            end
        end
    endtask

    task automatic test_random;
        int lat, port;
        bit we;
        logic [23:0] a;
        logic [31:0] wd, rd;
        p_full = 25; p_busy = 25; p_empty = 30;
        for (int i = 0; i < 40; i++) begin
            port = $urandom_range(1);
            we   = $urandom_range(1);
            a    = 24'h000300 + 24'($urandom_range(15));
            wd   = $urandom;
            wr_log.delete();
            rd_log.delete();
            do_req(port, we, a, wd, lat, rd);
            vectors++;
            if (lat < (we ? 3 : 5)) begin
                miscompares++;
                $display("FAIL random_latency: op %0d latency %0d below minimum %0d", i, lat, we ? 3 : 5);
            end
            if (we) begin
                check_wr_log("random", a, wd);
                wmem[a] = wd;
            end else begin
                check_rd_log("random", a);
                vectors++;
                if (rd !== exp_word(a)) begin
                    miscompares++;
                    $display("FAIL random_rdata: op %0d addr %h got %h required %h", i, a, rd, exp_word(a));
                end
            end
        end
        p_full = 0; p_busy = 0; p_empty = 0;
    endtask

    initial begin
        rst = 1;
        req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
        fifo_wr_full = 0; fifo_rd_busy = 0; fifo_rd_empty = 1; fifo_rd_data = '0;
        test_reset;
        test_write_basic;
        test_read_basic;
        test_wr_full;
        test_rd_empty;
        test_wrap;
        test_reset_mid;
        test_arbitration;
        test_random;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
